// File: rtl/ecs8_rst_pkg.sv
// Shared types and helpers for the ecs8 reset sequencer.
package ecs8_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // The PLL lock-loss cause bit sits just above the per-source bits:
  // cause index = N_SRC + CAUSE_PLL_OFS.
  localparam int CAUSE_PLL_OFS = 0;

  // Ceiling log2 for elaboration-time widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ecs8_sync.sv
// Multi-bit, multi-stage synchroniser with synchronous reset to RST_VAL.
module ecs8_sync #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;

  // Shift the asynchronous input through DEPTH flops.
  always_ff @(posedge clk) begin
    if (rst) stg <= {DEPTH{RST_VAL}};
    else     stg <= {stg[DEPTH-2:0], d};
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/ecs8_rst_seq.sv
// Board-level reset sequencer: debounced, staged release of N_OUT domains,
// sticky reset cause and a not-ready blink on the status LED.
module ecs8_rst_seq
  import ecs8_rst_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int N_OUT     = 3,
  parameter int DEBOUNCE  = 500,
  parameter int STAGE_DLY = 16,
  parameter int SYNC      = 2,
  parameter int BLINK_DIV = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_req,
  input  logic             pll_locked,
  input  logic             cause_clr,
  output logic [N_OUT-1:0] rst_o,
  output logic             ready,
  output logic [N_SRC:0]   cause,
  output logic             led_o
);

  localparam int CNT_W     = cw(DEBOUNCE);
  localparam int DLY_W     = cw(STAGE_DLY);
  localparam int REL_W     = cw(N_OUT + 1);
  localparam int BLK_W     = cw(BLINK_DIV);
  localparam int CAUSE_PLL = N_SRC + CAUSE_PLL_OFS;

  logic [N_SRC:0]   sync_q;
  logic [N_SRC-1:0] src_s;
  logic             pll_s;
  logic             req_any;
  logic [N_SRC:0]   cause_set;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DLY_W-1:0] dly, dly_nxt;
  logic [REL_W-1:0] rel, rel_nxt;
  logic [N_OUT-1:0] rst_o_nxt;
  logic             ready_nxt;
  logic [BLK_W-1:0] bcnt;

  // PLL lock resets to 0 so the sequencer treats the PLL as unlocked until
  // the synchroniser has filled.
  ecs8_sync #(
    .WIDTH   (N_SRC + 1),
    .DEPTH   (SYNC),
    .RST_VAL ('0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({pll_locked, src_req}),
    .q   (sync_q)
  );

  assign src_s   = sync_q[N_SRC-1:0];
  assign pll_s   = sync_q[N_SRC];
  assign req_any = (|src_s) | ~pll_s;

  // Cause bits to set this cycle; all zero whenever req_any is low.
  always_comb begin
    cause_set            = '0;
    cause_set[N_SRC-1:0] = src_s;
    cause_set[CAUSE_PLL] = ~pll_s;
  end

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dly_nxt   = dly;
    rel_nxt   = rel;
    case (state)
      HOLD: begin
        rel_nxt = '0;
        dly_nxt = '0;
        if (req_any) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
          cnt_nxt = '0;
          if (N_OUT == 1) begin
            state_nxt = RUN;
            rel_nxt   = REL_W'(N_OUT);
          end else begin
            state_nxt = RELEASE;
            rel_nxt   = REL_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (req_any) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          rel_nxt   = '0;
          dly_nxt   = '0;
        end else if (dly == DLY_W'(STAGE_DLY - 1)) begin
          dly_nxt = '0;
          rel_nxt = rel + REL_W'(1);
          if (rel_nxt == REL_W'(N_OUT)) state_nxt = RUN;
        end else begin
          dly_nxt = dly + DLY_W'(1);
        end
      end
      RUN: begin
        if (req_any) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          rel_nxt   = '0;
          dly_nxt   = '0;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
        rel_nxt   = '0;
        dly_nxt   = '0;
      end
    endcase

    for (int i = 0; i < N_OUT; i++)
      rst_o_nxt[i] = (state_nxt == HOLD) ||
                     ((state_nxt == RELEASE) && (i >= int'(rel_nxt)));
    ready_nxt = (state_nxt == RUN);
  end

  // State, counters and registered domain resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      cnt   <= '0;
      dly   <= '0;
      rel   <= '0;
      rst_o <= '1;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dly   <= dly_nxt;
      rel   <= rel_nxt;
      rst_o <= rst_o_nxt;
      ready <= ready_nxt;
    end
  end

  // Sticky cause: a set in the same cycle as a clear wins per bit.
  always_ff @(posedge clk) begin
    if (rst) cause <= '0;
    else     cause <= (cause & ~{(N_SRC + 1){cause_clr}}) | cause_set;
  end

  // LED blinks with half-period BLINK_DIV while not ready, dark when ready.
  always_ff @(posedge clk) begin
    if (rst || ready_nxt) begin
      bcnt  <= '0;
      led_o <= 1'b0;
    end else if (bcnt == BLK_W'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      led_o <= ~led_o;
    end else begin
      bcnt <= bcnt + BLK_W'(1);
    end
  end

endmodule

// File: tb/tb_ecs8_rst_seq.sv
// Self-checking bench for ecs8_rst_seq: per-scenario tables of expected
// outputs are queued against absolute edge numbers and checked as edges pass.
module tb_ecs8_rst_seq;

  localparam int N_SRC = 2, N_OUT = 3, DEBOUNCE = 8, STAGE_DLY = 4;
  localparam int SYNC = 2, BLINK_DIV = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] src_req;
  logic             pll_locked;
  logic             cause_clr;
  logic [N_OUT-1:0] rst_o;
  logic             ready;
  logic [N_SRC:0]   cause;
  logic             led_o;

  ecs8_rst_seq #(
    .N_SRC(N_SRC), .N_OUT(N_OUT), .DEBOUNCE(DEBOUNCE),
    .STAGE_DLY(STAGE_DLY), .SYNC(SYNC), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .pll_locked(pll_locked),
    .cause_clr(cause_clr), .rst_o(rst_o), .ready(ready), .cause(cause),
    .led_o(led_o)
  );

  initial forever #5 clk = ~clk;

  // ofs: edges after the scenario base; lm: whether led is checked.
  typedef struct {
    int         ofs;
    logic [2:0] ro;
    logic       rd;
    logic [2:0] ca;
    logic       lm;
    logic       led;
  } vec_t;

  typedef struct {
    int   at;
    int   sc;
    int   ix;
    vec_t v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  vec_t s1[7], s2[8], s3[8], s45[12], s6[8];

  task automatic push(input int at, input int sc, input int ix, input vec_t v);
    exp_t e;
    e.at = at; e.sc = sc; e.ix = ix; e.v = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [2:0] got,
                     input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL s%0d.%0d %s at edge %0d: got %b want %b",
               e.sc, e.ix, nm, e.at, got, want);
    end
  endtask

  // Compare every expectation due at the current edge.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        total++; bad++;
        $display("FAIL s%0d.%0d scoreboard_late: due edge %0d now %0d",
                 e.sc, e.ix, e.at, cyc);
      end else begin
        cmp("rst_o", e, rst_o, e.v.ro);
        cmp("ready", e, {2'b0, ready}, {2'b0, e.v.rd});
        cmp("cause", e, cause, e.v.ca);
        if (e.v.lm) cmp("led_o", e, {2'b0, led_o}, {2'b0, e.v.led});
      end
    end
  endtask

  // One clock: check outputs just after the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
    drain();
    @(negedge clk);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int base;
    vec_t v;

    s1 = '{'{1, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0}, '{9, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0},
           '{10, 3'b110, 1'b0, 3'b100, 1'b0, 1'b0}, '{13, 3'b110, 1'b0, 3'b100, 1'b0, 1'b0},
           '{14, 3'b100, 1'b0, 3'b100, 1'b0, 1'b0}, '{17, 3'b100, 1'b0, 3'b100, 1'b0, 1'b0},
           '{18, 3'b000, 1'b1, 3'b100, 1'b1, 1'b0}};
    s2 = '{'{1, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0}, '{7, 3'b111, 1'b0, 3'b100, 1'b0, 1'b0},
           '{8, 3'b111, 1'b0, 3'b101, 1'b0, 1'b0}, '{10, 3'b111, 1'b0, 3'b101, 1'b0, 1'b0},
           '{17, 3'b111, 1'b0, 3'b101, 1'b0, 1'b0}, '{18, 3'b110, 1'b0, 3'b101, 1'b0, 1'b0},
           '{22, 3'b100, 1'b0, 3'b101, 1'b0, 1'b0}, '{26, 3'b000, 1'b1, 3'b101, 1'b1, 1'b0}};
    s3 = '{'{1, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0}, '{3, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0},
           '{4, 3'b111, 1'b0, 3'b010, 1'b0, 1'b0}, '{11, 3'b111, 1'b0, 3'b010, 1'b0, 1'b0},
           '{12, 3'b110, 1'b0, 3'b010, 1'b0, 1'b0}, '{16, 3'b100, 1'b0, 3'b010, 1'b0, 1'b0},
           '{19, 3'b100, 1'b0, 3'b010, 1'b0, 1'b0}, '{20, 3'b000, 1'b1, 3'b010, 1'b1, 1'b0}};
    s45 = '{'{2, 3'b000, 1'b1, 3'b010, 1'b1, 1'b0}, '{3, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0},
            '{10, 3'b111, 1'b0, 3'b001, 1'b0, 1'b0}, '{11, 3'b110, 1'b0, 3'b001, 1'b0, 1'b0},
            '{15, 3'b100, 1'b0, 3'b001, 1'b0, 1'b0}, '{17, 3'b100, 1'b0, 3'b001, 1'b0, 1'b0},
            '{18, 3'b111, 1'b0, 3'b101, 1'b0, 1'b0}, '{25, 3'b111, 1'b0, 3'b101, 1'b0, 1'b0},
            '{26, 3'b110, 1'b0, 3'b101, 1'b0, 1'b0}, '{30, 3'b100, 1'b0, 3'b101, 1'b0, 1'b0},
            '{33, 3'b100, 1'b0, 3'b101, 1'b0, 1'b0}, '{34, 3'b000, 1'b1, 3'b101, 1'b1, 1'b0}};
    s6 = '{'{1, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0}, '{5, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0},
           '{6, 3'b111, 1'b0, 3'b100, 1'b1, 1'b1}, '{10, 3'b111, 1'b0, 3'b100, 1'b1, 1'b1},
           '{11, 3'b110, 1'b0, 3'b100, 1'b1, 1'b0}, '{16, 3'b100, 1'b0, 3'b100, 1'b1, 1'b1},
           '{18, 3'b100, 1'b0, 3'b100, 1'b1, 1'b1}, '{19, 3'b000, 1'b1, 3'b100, 1'b1, 1'b0}};

    rst = 1'b1; src_req = '0; pll_locked = 1'b1; cause_clr = 1'b0;
    tick(); tick();

    // Reset state, then power-up release (base = last edge with rst high).
    v = '{0, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0};
    push(cyc + 1, 0, 0, v);
    tick();
    base = cyc; rst = 1'b0;
    foreach (s1[i]) push(base + s1[i].ofs, 1, i, s1[i]);
    wait_to(base + 18);
    cause_clr = 1'b1;
    v = '{0, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0};
    push(cyc + 1, 1, 99, v);
    tick();
    cause_clr = 1'b0;

    // Three-cycle src_req[0] glitch in the middle of the debounce window.
    rst = 1'b1;
    tick();
    base = cyc; rst = 1'b0;
    foreach (s2[i]) push(base + s2[i].ofs, 2, i, s2[i]);
    wait_to(base + 5);  src_req[0] = 1'b1;
    wait_to(base + 8);  src_req[0] = 1'b0;
    wait_to(base + 26);

    // Clear cause, then a single-cycle src_req[1] pulse while running.
    base = cyc; cause_clr = 1'b1;
    foreach (s3[i]) push(base + s3[i].ofs, 3, i, s3[i]);
    tick(); cause_clr = 1'b0; src_req[1] = 1'b1;
    tick(); src_req[1] = 1'b0;
    wait_to(base + 20);

    // cause_clr coincides with a new src_req[0] set; then a one-cycle PLL
    // lock drop while two domains are released.
    base = cyc; src_req[0] = 1'b1;
    foreach (s45[i]) push(base + s45[i].ofs, 4, i, s45[i]);
    tick(); src_req[0] = 1'b0;
    tick(); cause_clr = 1'b1;
    tick(); cause_clr = 1'b0;
    wait_to(base + 15); pll_locked = 1'b0;
    tick(); pll_locked = 1'b1;
    wait_to(base + 34);

    // Reset while running, then LED blink until ready again.
    base = cyc; rst = 1'b1;
    foreach (s6[i]) push(base + s6[i].ofs, 6, i, s6[i]);
    tick(); rst = 1'b0;
    wait_to(base + 19);

    for (int n = 0; n < 50 && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
